// File: rtl/pu_or1k_pfpu64_cnv_sched.sv
// Round-robin scheduler sharing one pipelined pfpu64 conversion datapath between f2i and i2f requesters.
// Optional stall counter is enabled by defining PFPU64_CNV_STALL_CNT_EN.
module pu_or1k_pfpu64_cnv_sched #(
   parameter int LAT  = 3,
   parameter int TAGW = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush_i,
   input  logic [1:0]      req_i,
   input  logic [TAGW-1:0] tag0_i,
   input  logic [TAGW-1:0] tag1_i,
   output logic [1:0]      gnt_o,
   output logic            dp_start_o,
   output logic            dp_op_o,
   output logic            dp_adv_o,
   output logic            dp_flush_o,
   output logic            out_valid_o,
   output logic            out_op_o,
   output logic [TAGW-1:0] out_tag_o,
   input  logic            out_ready_i,
   output logic            busy_o,
   output logic [3:0]      inflight_o,
   output logic [15:0]     stall_cnt_o
);

   logic [LAT-1:0]  v;
   logic [LAT-1:0]  op;
   logic [TAGW-1:0] tag [LAT];
   logic            rr;
   logic            sel_op;
   logic [TAGW-1:0] sel_tag;

   // The whole pipe moves in lockstep; only an unaccepted result at the output freezes it.
   assign dp_adv_o = ~(v[LAT-1] & ~out_ready_i);

   always_comb begin
      gnt_o = 2'b00;
      if (!rst && !flush_i && dp_adv_o) begin
         case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = rr ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
         endcase
      end
   end

   assign sel_op     = gnt_o[1];
   assign sel_tag    = gnt_o[1] ? tag1_i : tag0_i;
   assign dp_start_o = |gnt_o;
   assign dp_op_o    = sel_op;
   assign dp_flush_o = flush_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: op/tag are payload and functionally don't-care when invalid; they are
         // reset anyway so the output fields read a defined 0 after reset.
         v  <= '0;
         op <= '0;
         for (int s = 0; s < LAT; s++) tag[s] <= '0;
         rr <= 1'b0;
      end else begin
         if (|gnt_o) rr <= gnt_o[0];
         if (flush_i) begin
            v <= '0;
         end else if (dp_adv_o) begin
            for (int s = LAT - 1; s > 0; s--) begin
               v[s]   <= v[s-1];
               op[s]  <= op[s-1];
               tag[s] <= tag[s-1];
            end
            v[0]   <= |gnt_o;
            op[0]  <= sel_op;
            tag[0] <= sel_tag;
         end
      end
   end

   assign out_valid_o = v[LAT-1];
   assign out_op_o    = op[LAT-1];
   assign out_tag_o   = tag[LAT-1];
   assign busy_o      = |v;

   always_comb begin
      inflight_o = 4'd0;
      for (int s = 0; s < LAT; s++) inflight_o = inflight_o + 4'(v[s]);
   end

`ifdef PFPU64_CNV_STALL_CNT_EN
   logic [15:0] stall_cnt;

   // Counts cycles where a requester is blocked by output backpressure; flush does not clear it.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= 16'h0000;
      end else if (!dp_adv_o && (|req_i) && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign stall_cnt_o = stall_cnt;
`else
   assign stall_cnt_o = 16'h0000;
`endif

endmodule
